// File: rtl/wb_pkg.sv
// Shared types and parameter defaults for the writeback arbiter slice.
package wb_pkg;

    localparam int FIFO_DEPTH_DEFAULT   = 2;
    localparam int STARVE_LIMIT_DEFAULT = 3;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of ALU/LSU result, load-issue, hazard-query and register-file write signals.
interface wb_arbiter_if;

    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        RegWEn;
    logic [4:0]  rs3;
    logic [31:0] dataW;
    logic        stall_o;
    logic        err_o;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd, rs1_q, rs2_q,
        output lsu_ready, rs1_busy, rs2_busy,
        output RegWEn, rs3, dataW, stall_o, err_o
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd, rs1_q, rs2_q,
        input  lsu_ready, rs1_busy, rs2_busy,
        input  RegWEn, rs3, dataW, stall_o, err_o
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback entries; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_entry_t      mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback port arbiter: ALU results win, buffered LSU results fill idle
// cycles, with a starvation-driven stall and a load scoreboard.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_arbiter_if.slave  bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t      lsu_entry;
    wb_entry_t      head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           lsu_push;
    logic           alu_grant;
    logic           fifo_grant;
    logic           starve_lose;
    logic           starve_hit;
    logic [SW-1:0]  starve_cnt;
    logic           stall_q;
    logic           err_q;
    logic           we_q;
    logic [4:0]     rd_q;
    logic [31:0]    data_q;
    logic [31:0]    busy;
    logic [31:0]    set_mask;
    logic [31:0]    clr_mask;

    assign lsu_entry = '{rd: bus.lsu_rd, data: bus.lsu_data};
    assign lsu_push  = bus.lsu_valid && !fifo_full;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (lsu_push),
        .pop   (fifo_grant),
        .din   (lsu_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // During a stall cycle the ALU beat is dropped and the FIFO head takes the port.
    assign alu_grant   = bus.alu_valid && !stall_q;
    assign fifo_grant  = !fifo_empty && (!bus.alu_valid || stall_q);
    assign starve_lose = !fifo_empty && alu_grant;
    assign starve_hit  = starve_lose && (starve_cnt == SW'(STARVE_LIMIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else if (alu_grant) begin
            we_q   <= (bus.alu_rd != 5'd0);
            rd_q   <= bus.alu_rd;
            data_q <= bus.alu_data;
        end else if (fifo_grant) begin
            we_q   <= (head.rd != 5'd0);
            rd_q   <= head.rd;
            data_q <= head.data;
        end else begin
            we_q   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            starve_cnt <= starve_lose ? starve_cnt + 1'b1 : '0;
            stall_q    <= starve_hit;
            err_q      <= err_q | (bus.alu_valid && stall_q);
        end
    end

    // A new load to the same register must stay pending, so the set is applied last.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (bus.issue_valid && bus.issue_rd != 5'd0) set_mask[bus.issue_rd] = 1'b1;
        if (fifo_grant && head.rd != 5'd0)           clr_mask[head.rd]      = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~clr_mask) | set_mask;
    end

    assign bus.lsu_ready = !fifo_full;
    assign bus.rs1_busy  = (bus.rs1_q != 5'd0) && busy[bus.rs1_q];
    assign bus.rs2_busy  = (bus.rs2_q != 5'd0) && busy[bus.rs2_q];
    assign bus.RegWEn    = we_q;
    assign bus.rs3       = rd_q;
    assign bus.dataW     = data_q;
    assign bus.stall_o   = stall_q;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter with a negedge-sampled register file model.
module tb_wb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        rf_init;
    logic [31:0] regs [32];
    int          checks;
    int          passes;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: clears while rf_init is high, then writes on negedge.
    always @(negedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (bus.RegWEn) begin
            regs[bus.rs3] <= bus.dataW;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        bus.alu_valid = av;
        bus.alu_rd    = ard;
        bus.alu_data  = adata;
        bus.lsu_valid = lv;
        bus.lsu_rd    = lrd;
        bus.lsu_data  = ldata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic step_clock();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        rf_init = 1'b1;
        rst_n = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.issue_valid = 1'b0;
        bus.issue_rd    = 5'd0;
        bus.rs1_q       = 5'd0;
        bus.rs2_q       = 5'd0;

        #12;
        checkOutput("reset_we",    32'(bus.RegWEn),    32'd0);
        checkOutput("reset_rs3",   32'(bus.rs3),       32'd0);
        checkOutput("reset_dataW", bus.dataW,          32'd0);
        checkOutput("reset_stall", 32'(bus.stall_o),   32'd0);
        checkOutput("reset_err",   32'(bus.err_o),     32'd0);
        checkOutput("reset_ready", 32'(bus.lsu_ready), 32'd1);
        rf_init = 1'b0;
        rst_n   = 1'b1;

        // Lone ALU beat, granted on the first edge after reset release.
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("alu_we",    32'(bus.RegWEn), 32'd1);
        checkOutput("alu_rs3",   32'(bus.rs3),    32'd5);
        checkOutput("alu_dataW", bus.dataW,       32'hDEADBEEF);
        @(negedge clk);
        #1;
        checkOutput("rf_x5", regs[5], 32'hDEADBEEF);
        step_clock();
        checkOutput("idle_we",  32'(bus.RegWEn), 32'd0);
        checkOutput("idle_rs3", 32'(bus.rs3),    32'd5);

        // Load to x9 issued, then an unrelated LSU beat to x7.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd9;
        step_clock();
        bus.issue_valid = 1'b0;
        bus.rs1_q = 5'd9;
        bus.rs2_q = 5'd0;
        #1;
        checkOutput("busy9_set",  32'(bus.rs1_busy), 32'd1);
        checkOutput("busy0_zero", 32'(bus.rs2_busy), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("lsu_lat1_we", 32'(bus.RegWEn), 32'd0);
        step_clock();
        checkOutput("lsu_we",    32'(bus.RegWEn), 32'd1);
        checkOutput("lsu_rs3",   32'(bus.rs3),    32'd7);
        checkOutput("lsu_dataW", bus.dataW,       32'h12345678);
        checkOutput("busy9_hold", 32'(bus.rs1_busy), 32'd1);

        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h00000099);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("busy9_queued", 32'(bus.rs1_busy), 32'd1);
        step_clock();
        checkOutput("lsu9_rs3",    32'(bus.rs3),      32'd9);
        checkOutput("busy9_clear", 32'(bus.rs1_busy), 32'd0);

        // Set and clear of x4 on the same edge: the set must win.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd4;
        bus.rs2_q       = 5'd4;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step_clock();
        bus.issue_valid = 1'b0;
        checkOutput("setwin_rs3",  32'(bus.rs3),      32'd4);
        checkOutput("setwin_busy", 32'(bus.rs2_busy), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        step_clock();
        checkOutput("busy4_clear", 32'(bus.rs2_busy), 32'd0);

        // Fill the FIFO while the ALU hogs the port until the stall fires.
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB1);
        step_clock();
        checkOutput("fill1_rs3",   32'(bus.rs3),       32'd10);
        checkOutput("fill1_ready", 32'(bus.lsu_ready), 32'd1);
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd12, 32'hB2);
        step_clock();
        checkOutput("full_ready", 32'(bus.lsu_ready), 32'd0);
        checkOutput("lose1_stall", 32'(bus.stall_o), 32'd0);
        applyStimulus(1'b1, 5'd10, 32'hA0, 1'b1, 5'd13, 32'hB3);
        step_clock();
        checkOutput("lose2_stall", 32'(bus.stall_o), 32'd0);
        step_clock();
        checkOutput("lose3_stall", 32'(bus.stall_o), 32'd1);
        checkOutput("lose3_rs3",   32'(bus.rs3),     32'd10);
        step_clock();
        checkOutput("post_stall",  32'(bus.stall_o),   32'd0);
        checkOutput("drop_err",    32'(bus.err_o),     32'd1);
        checkOutput("stall_we",    32'(bus.RegWEn),    32'd1);
        checkOutput("stall_rs3",   32'(bus.rs3),       32'd11);
        checkOutput("stall_dataW", bus.dataW,          32'hB1);
        checkOutput("stall_ready", 32'(bus.lsu_ready), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hB3);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("pushpop_rs3",   32'(bus.rs3),       32'd12);
        checkOutput("pushpop_ready", 32'(bus.lsu_ready), 32'd1);
        step_clock();
        checkOutput("third_rs3",   32'(bus.rs3), 32'd13);
        checkOutput("third_dataW", bus.dataW,    32'hB3);
        step_clock();
        checkOutput("drain_we",   32'(bus.RegWEn), 32'd0);
        checkOutput("err_sticky", 32'(bus.err_o),  32'd1);

        // Register 0 beats are consumed without writing.
        applyStimulus(1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
        step_clock();
        checkOutput("alu_x0_we", 32'(bus.RegWEn), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h66);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd14, 32'h77);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("lsu_x0_we", 32'(bus.RegWEn), 32'd0);
        step_clock();
        checkOutput("after_x0_rs3",   32'(bus.rs3), 32'd14);
        checkOutput("after_x0_dataW", bus.dataW,    32'h77);

        // Reset with two buffered beats and x3 pending.
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'd3;
        applyStimulus(1'b1, 5'd20, 32'h1, 1'b1, 5'd3, 32'h33);
        step_clock();
        bus.issue_valid = 1'b0;
        applyStimulus(1'b1, 5'd20, 32'h1, 1'b1, 5'd5, 32'h55);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        bus.rs1_q = 5'd3;
        #1;
        checkOutput("prerst_ready", 32'(bus.lsu_ready), 32'd0);
        checkOutput("prerst_busy3", 32'(bus.rs1_busy),  32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_we",    32'(bus.RegWEn),    32'd0);
        checkOutput("rst_rs3",   32'(bus.rs3),       32'd0);
        checkOutput("rst_dataW", bus.dataW,          32'd0);
        checkOutput("rst_stall", 32'(bus.stall_o),   32'd0);
        checkOutput("rst_err",   32'(bus.err_o),     32'd0);
        checkOutput("rst_ready", 32'(bus.lsu_ready), 32'd1);
        checkOutput("rst_busy3", 32'(bus.rs1_busy),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step_clock();
        checkOutput("postrst_we1", 32'(bus.RegWEn), 32'd0);
        step_clock();
        checkOutput("postrst_we2",   32'(bus.RegWEn),    32'd0);
        checkOutput("postrst_ready", 32'(bus.lsu_ready), 32'd1);
        applyStimulus(1'b1, 5'd21, 32'h21, 1'b0, 5'd0, 32'h0);
        step_clock();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        checkOutput("postrst_alu_rs3", 32'(bus.rs3), 32'd21);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
